// File: rtl/text_cursor_writer.sv
// text_cursor_writer: tracks the text cursor and drives frame RAM writes, blanking each newly entered row.
module text_cursor_writer #(
    parameter int DATA_WIDTH       = 9,
    parameter int ROWS             = 4,
    parameter int COLS             = 32,
    parameter bit CLEAR_ON_NEWLINE = 1'b1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [DATA_WIDTH-1:0]   in_char,
    input  logic                    in_lang,
    output logic                    we,
    output logic [$clog2(ROWS)-1:0] w_row,
    output logic [$clog2(COLS)-1:0] w_col,
    output logic [DATA_WIDTH-1:0]   din,
    output logic                    langin,
    output logic [$clog2(ROWS)-1:0] cur_row,
    output logic [$clog2(COLS)-1:0] cur_col,
    output logic                    busy
);
    localparam int RW = $clog2(ROWS);
    localparam int CW = $clog2(COLS);
    localparam logic [RW-1:0] MAX_ROW = RW'(ROWS - 1);
    localparam logic [CW-1:0] MAX_COL = CW'(COLS - 1);
    localparam logic [CW:0]   CNT_END = (CW + 1)'(COLS);
    localparam logic [DATA_WIDTH-1:0] C_NUL = DATA_WIDTH'(8'h00);
    localparam logic [DATA_WIDTH-1:0] C_BS  = DATA_WIDTH'(8'h08);
    localparam logic [DATA_WIDTH-1:0] C_LF  = DATA_WIDTH'(8'h0A);
    localparam logic [DATA_WIDTH-1:0] C_CR  = DATA_WIDTH'(8'h0D);

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t                  state, state_n;
    logic [RW-1:0]           row_n, w_row_n;
    logic [CW-1:0]           col_n, w_col_n;
    logic [CW:0]             clr_cnt, cnt_n;
    logic [DATA_WIDTH-1:0]   din_n;
    logic                    we_n, lang_n, busy_n, nl, accept;

    assign in_ready = (state == IDLE) && !reset;
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            cur_row <= '0;
            cur_col <= '0;
            clr_cnt <= '0;
            we      <= 1'b0;
            w_row   <= '0;
            w_col   <= '0;
            din     <= '0;
            langin  <= 1'b0;
            busy    <= 1'b0;
        end else begin
            state   <= state_n;
            cur_row <= row_n;
            cur_col <= col_n;
            clr_cnt <= cnt_n;
            we      <= we_n;
            w_row   <= w_row_n;
            w_col   <= w_col_n;
            din     <= din_n;
            langin  <= lang_n;
            busy    <= busy_n;
        end
    end

    // CLEAR lingers one extra count so busy covers the visible cycle of the last blank write
    always_comb begin
        state_n = state;
        row_n   = cur_row;
        col_n   = cur_col;
        cnt_n   = clr_cnt;
        we_n    = 1'b0;
        w_row_n = w_row;
        w_col_n = w_col;
        din_n   = din;
        lang_n  = langin;
        busy_n  = busy;
        nl      = 1'b0;
        if (state == CLEAR) begin
            if (clr_cnt == CNT_END) begin
                state_n = IDLE;
                busy_n  = 1'b0;
            end else begin
                we_n    = 1'b1;
                w_row_n = cur_row;
                w_col_n = clr_cnt[CW-1:0];
                din_n   = '0;
                lang_n  = 1'b0;
                cnt_n   = clr_cnt + 1'b1;
            end
        end else if (accept) begin
            if (in_char == C_CR) begin
                col_n = '0;
            end else if (in_char == C_LF) begin
                nl = 1'b1;
            end else if (in_char == C_BS) begin
                if (cur_col != '0) begin
                    col_n   = cur_col - 1'b1;
                    we_n    = 1'b1;
                    w_row_n = cur_row;
                    w_col_n = cur_col - 1'b1;
                    din_n   = '0;
                    lang_n  = 1'b0;
                end
            end else if (in_char != C_NUL) begin
                we_n    = 1'b1;
                w_row_n = cur_row;
                w_col_n = cur_col;
                din_n   = in_char;
                lang_n  = in_lang;
                col_n   = cur_col + 1'b1;
                nl      = (cur_col == MAX_COL);
            end
        end
        if (nl) begin
            col_n = '0;
            row_n = (cur_row == MAX_ROW) ? '0 : cur_row + 1'b1;
            if (CLEAR_ON_NEWLINE) begin
                state_n = CLEAR;
                busy_n  = 1'b1;
                cnt_n   = '0;
            end
        end
    end
endmodule
